// File: rtl/core_pkg.sv
// Shared core types: memory-port arbiter state encoding and address/wdata mux select values.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2
    } arb_state_t;

    // Mux convention: input A carries the fetch address, input B the data address/wdata.
    localparam logic SEL_FETCH = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch and data access, one access at a time,
// data-first with a fairness cap on consecutive data grants and a hung-access timeout.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned DATA_STREAK_MAX = 3,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic mem_ready,
    output logic sel,
    output logic mem_req,
    output logic if_gnt,
    output logic dm_gnt,
    output logic if_done,
    output logic dm_done,
    output logic bus_err
);

    localparam int unsigned STREAK_W = 4;
    localparam int unsigned TCOUNT_W = 8;

    arb_state_t          state_q, state_d;
    logic                sel_q, sel_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TCOUNT_W-1:0] tcount_q, tcount_d;
    logic                done_c;
    logic                timeout_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= SEL_FETCH;
            streak_q <= '0;
            tcount_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            streak_q <= streak_d;
            tcount_q <= tcount_d;
        end
    end

    // Next-state: arbitrate in IDLE and in any completion cycle; timeout forces IDLE.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tcount_d = tcount_q;
        done_c    = (state_q != IDLE) && mem_ready;
        timeout_c = (TIMEOUT_CYCLES != 0) && (state_q != IDLE) && !mem_ready &&
                    (tcount_q == TCOUNT_W'(TIMEOUT_CYCLES - 1));

        if ((state_q != IDLE) && !mem_ready && (tcount_q != '1)) begin
            tcount_d = tcount_q + TCOUNT_W'(1);
        end

        if (timeout_c) begin
            state_d  = IDLE;
            tcount_d = '0;
        end else if ((state_q == IDLE) || done_c) begin
            tcount_d = '0;
            if (dm_req && (!if_req || (streak_q != STREAK_W'(DATA_STREAK_MAX)))) begin
                state_d = GRANT_DM;
                // Streak only tracks data grants that made a waiting fetch wait longer.
                if (if_req) begin
                    streak_d = (streak_q == STREAK_W'(DATA_STREAK_MAX)) ? streak_q
                                                                       : streak_q + STREAK_W'(1);
                end else begin
                    streak_d = '0;
                end
            end else if (if_req) begin
                state_d  = GRANT_IF;
                streak_d = '0;
            end else begin
                state_d = IDLE;
            end
        end

        sel_d = (state_d == GRANT_DM) ? SEL_DATA : SEL_FETCH;
    end

    // Pulses are suppressed while reset is asserted so an aborted access reports nothing.
    assign sel     = sel_q;
    assign mem_req = (state_q != IDLE);
    assign if_gnt  = (state_q == GRANT_IF);
    assign dm_gnt  = (state_q == GRANT_DM);
    assign if_done = (state_q == GRANT_IF) && mem_ready && !rst;
    assign dm_done = (state_q == GRANT_DM) && mem_ready && !rst;
    assign bus_err = timeout_c && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a per-cycle expected-output scoreboard.
module tb_mem_port_arbiter;

    localparam int S_I = 0;
    localparam int S_F = 1;
    localparam int S_D = 2;

    logic clk;
    logic rst;
    logic if_req;
    logic dm_req;
    logic mem_ready;
    logic sel;
    logic mem_req;
    logic if_gnt;
    logic dm_gnt;
    logic if_done;
    logic dm_done;
    logic bus_err;

    int total;
    int bad;
    logic [6:0] exp_q[$];

    mem_port_arbiter #(
        .DATA_STREAK_MAX(3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .mem_ready(mem_ready),
        .sel      (sel),
        .mem_req  (mem_req),
        .if_gnt   (if_gnt),
        .dm_gnt   (dm_gnt),
        .if_done  (if_done),
        .dm_done  (dm_done),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector {sel, mem_req, if_gnt, dm_gnt, if_done, dm_done, bus_err}.
    function automatic logic [6:0] exp_vec(input int st, input logic ifd, input logic dmd,
                                           input logic err);
        logic [6:0] v;
        v[6] = (st == S_D);
        v[5] = (st != S_I);
        v[4] = (st == S_F);
        v[3] = (st == S_D);
        v[2] = ifd;
        v[1] = dmd;
        v[0] = err;
        return v;
    endfunction

    // Drive one cycle of inputs just after the edge, then check outputs at the falling edge.
    task automatic step(input string tag, input logic r, input logic ir, input logic dr,
                        input logic rdy, input int st, input logic ifd, input logic dmd,
                        input logic err);
        logic [6:0] obs;
        logic [6:0] exp;
        @(posedge clk);
        #1;
        rst       = r;
        if_req    = ir;
        dm_req    = dr;
        mem_ready = rdy;
        exp_q.push_back(exp_vec(st, ifd, dmd, err));
        @(negedge clk);
        obs = {sel, mem_req, if_gnt, dm_gnt, if_done, dm_done, bus_err};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty obs=%b", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        if_req    = 1'b1;
        dm_req    = 1'b1;
        mem_ready = 1'b0;

        // Reset with both requests high: everything quiet.
        step("rst_a", 1, 1, 1, 0, S_I, 0, 0, 0);
        step("rst_b", 1, 1, 1, 0, S_I, 0, 0, 0);
        step("rst_rel", 0, 1, 1, 0, S_I, 0, 0, 0);

        // Fairness: both held, immediate completion -> D,D,D,F,D,D,D,F with no IDLE gaps.
        step("fair1_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("fair2_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("fair3_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("fair4_f", 0, 1, 1, 1, S_F, 1, 0, 0);
        step("fair5_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("fair6_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("fair7_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("fair8_f", 0, 0, 0, 1, S_F, 1, 0, 0);
        step("fair_idle", 0, 0, 0, 0, S_I, 0, 0, 0);
        step("idle_rdy", 0, 0, 0, 1, S_I, 0, 0, 0);

        // Single fetch with a three-cycle wait, request dropped in the done cycle.
        step("fetch_req", 0, 1, 0, 0, S_I, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("fetch_wait", 0, 1, 0, 0, S_F, 0, 0, 0);
        step("fetch_done", 0, 0, 0, 1, S_F, 1, 0, 0);
        step("fetch_idle", 0, 0, 0, 0, S_I, 0, 0, 0);

        // Timeout: no mem_ready, error on the 16th grant cycle, done suppressed.
        step("to_req", 0, 0, 1, 0, S_I, 0, 0, 0);
        for (int i = 1; i < 16; i++) step("to_wait", 0, 0, 1, 0, S_D, 0, 0, 0);
        step("to_err", 0, 0, 1, 0, S_D, 0, 0, 1);
        step("to_idle", 0, 0, 0, 0, S_I, 0, 0, 0);

        // Completion on the 16th grant cycle beats the timeout.
        step("tr_req", 0, 0, 1, 0, S_I, 0, 0, 0);
        for (int i = 1; i < 16; i++) step("tr_wait", 0, 0, 1, 0, S_D, 0, 0, 0);
        step("tr_done", 0, 0, 0, 1, S_D, 0, 1, 0);
        step("tr_idle", 0, 0, 0, 0, S_I, 0, 0, 0);

        // Reset mid-access (even with mem_ready high) gives no pulse and returns to IDLE.
        step("mr_req", 0, 1, 0, 0, S_I, 0, 0, 0);
        step("mr_wait1", 0, 1, 0, 0, S_F, 0, 0, 0);
        step("mr_wait2", 0, 1, 0, 0, S_F, 0, 0, 0);
        step("mr_rst", 1, 1, 0, 1, S_F, 0, 0, 0);
        step("mr_idle", 0, 0, 0, 0, S_I, 0, 0, 0);

        // Simultaneous arrival from IDLE: DM first, then IF right after dm_done.
        step("sim_req", 0, 1, 1, 0, S_I, 0, 0, 0);
        step("sim_dm", 0, 1, 0, 1, S_D, 0, 1, 0);
        step("sim_if", 0, 0, 0, 1, S_F, 1, 0, 0);
        step("sim_idle", 0, 0, 0, 0, S_I, 0, 0, 0);

        // Streak after mid-access reset is zero: three DM grants before IF again.
        step("st_req", 0, 1, 1, 0, S_I, 0, 0, 0);
        step("st1_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("st2_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("st3_d", 0, 1, 1, 1, S_D, 0, 1, 0);
        step("st4_f", 0, 0, 0, 1, S_F, 1, 0, 0);
        step("st_idle", 0, 0, 0, 0, S_I, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and data access (DM) in the RV32I core.
- Owns the select line of the existing 32-bit 2-to-1 address/wdata mux: sel=0 routes input A (fetch address), sel=1 routes input B (data address/wdata).
- Sequences one memory access at a time with a req/ready handshake, prioritises data over fetch with a fairness cap, and aborts hung accesses via a timeout.

Parameters:
- DATA_STREAK_MAX, 3: max consecutive DM grants while IF is waiting; 1..15.
- TIMEOUT_CYCLES, 16: cycles in a grant state without mem_ready before abort; 0 disables; max 255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch wants an access; held until if_done or bus_err.
- dm_req  in  1  load/store wants an access; held until dm_done or bus_err.
- mem_ready  in  1  memory completes the current access this cycle.
- sel  out  1  mux select: 0 = fetch (A), 1 = data (B).
- mem_req  out  1  access in flight to memory.
- if_gnt  out  1  IF owns the port.
- dm_gnt  out  1  DM owns the port.
- if_done  out  1  one-cycle pulse: IF access completed.
- dm_done  out  1  one-cycle pulse: DM access completed.
- bus_err  out  1  one-cycle pulse: current access aborted by timeout.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: IDLE, GRANT_IF, GRANT_DM. State, sel, streak and timeout counters are registered.
- Reset values: state=IDLE, sel=0, mem_req=0, if_gnt=0, dm_gnt=0, if_done=0, dm_done=0, bus_err=0, streak=0, tcount=0.
- rst asserted mid-access: next edge goes to IDLE. No done or err pulse is issued. Memory must tolerate a dropped mem_req.
- Decoded outputs:
  - mem_req = (state != IDLE).
  - if_gnt = (state == GRANT_IF); dm_gnt = (state == GRANT_DM).
  - sel = 1 only in GRANT_DM. sel = 0 in IDLE and GRANT_IF.
  - if_done = GRANT_IF & mem_ready; dm_done = GRANT_DM & mem_ready. These are combinational and fire in the same cycle as mem_ready.
- Arbitration runs in IDLE, and in any cycle where a done pulse fires:
  - Only one request pending: grant it.
  - Both pending: DM wins, unless streak == DATA_STREAK_MAX, in which case IF wins.
  - No request pending: go to (or stay in) IDLE.
- Latency: a request seen in IDLE is granted at the next edge, giving 1 cycle of req-to-mem_req latency.
- Back-to-back accesses: a req that is high in the done cycle counts as a new request. The next grant takes effect at the next edge, with no IDLE bubble. A continuously asserted if_req streams fetches.
- Streak counter:
  - Increments on each DM grant taken while if_req=1.
  - Clears on any IF grant, and whenever if_req=0 at a DM grant.
  - Saturates at DATA_STREAK_MAX.
- Timeout:
  - tcount clears on entering a grant state and increments each cycle in a grant state without mem_ready.
  - When TIMEOUT_CYCLES != 0 and tcount == TIMEOUT_CYCLES-1 with mem_ready=0: pulse bus_err, suppress done, go to IDLE. The requester then drops or retries its req.
  - mem_ready in the same cycle as the timeout: completion wins (done pulse, no err).
- Requests are ignored while in a grant state, except in the done cycle. A req drop mid-grant does not abort the access.

Decomposition:
- Shared package core_pkg: enum arb_state_t {IDLE, GRANT_IF, GRANT_DM}; constants SEL_FETCH=1'b0 and SEL_DATA=1'b1, matching the mux A/B convention.
- No sub-module. At top level, sel drives the existing 2-to-1 mux instance directly.

Test Plan:
- Reset: assert rst 2 cycles with both reqs high -> all outputs 0, state IDLE. Release -> dm_gnt=1, sel=1, mem_req=1 on the next edge.
- Single fetch: if_req=1, mem_ready high 3 cycles after grant -> if_gnt/sel=0 held 3 cycles, if_done one cycle. if_req low in the done cycle -> IDLE next edge.
- Fairness, DATA_STREAK_MAX=3: both reqs held high, mem_ready=1 in every grant cycle -> grant order DM,DM,DM,IF,DM,DM,DM,IF. sel toggles accordingly with no IDLE cycles.
- Timeout, TIMEOUT_CYCLES=16: DM granted, mem_ready never high -> bus_err pulses on the 16th grant cycle, dm_done stays 0, IDLE next edge. Repeat with mem_ready arriving on cycle 16 -> dm_done=1, bus_err=0.
- Mid-access reset: GRANT_IF at cycle 2 of wait, rst pulsed one cycle -> IDLE next edge, no if_done or bus_err, streak=0.
- Simultaneous arrival from IDLE: if_req and dm_req rise together, streak=0 -> DM granted first. IF granted immediately after dm_done, and sel goes 1 then 0.
